// File: rtl/uart_cmd_pkg.sv
// Shared constants for the host serial command endpoint.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_cmd_pkg;

  localparam int CMD_BYTES  = 3;   // bytes per host command
  localparam int FRAME_BITS = 10;  // 8N1: start + 8 data + stop

  // RX engine states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // TX engine states
  localparam logic TX_IDLE = 1'b0;
  localparam logic TX_XMIT = 1'b1;

endpackage

// File: rtl/uart_cmd_comm_if.sv
// Core-side bundle of the serial endpoint: assembled command out, response byte in.
// Latency: n/a (wiring only).
// Backpressure: cmd held while cmd_rdy until clr_cmd_rdy; send_resp ignored while a frame is in flight.
// master = core (dig_core), slave = uart_cmd_comm.
interface uart_cmd_comm_if;
  logic [23:0] cmd;          // assembled command, byte 1 in [23:16]
  logic        cmd_rdy;      // level: cmd valid
  logic        clr_cmd_rdy;  // pulse: release cmd, re-arm assembly
  logic [7:0]  resp_data;    // response byte
  logic        send_resp;    // pulse: start transmitting resp_data
  logic        resp_sent;    // pulse: response frame fully sent

  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp_data, send_resp
  );

  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp_data, send_resp
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-clk rx_byte_vld per good frame.
// Latency: rx_byte_vld one clk after the stop-bit sample (plus 2 clk synchronizer delay).
// Backpressure: none; a frame with a low stop bit is silently dropped.
// Ports: clk, rst_n, rx (async line) -> rx_data[7:0], rx_byte_vld.
module uart_rx import uart_cmd_pkg::*; #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_byte_vld
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= 2'b11;  // idle-high line, no false start edge out of reset
      rx_prev     <= 1'b1;
      state       <= RX_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_byte_vld <= 1'b0;
    end else begin
      sync        <= {sync[0], rx};
      rx_prev     <= rx_s;
      rx_byte_vld <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (rx_prev && !rx_s) state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: still low means a real start bit, high means a glitch.
          if (baud_cnt == HALF_END) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};  // LSB first
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin  // RX_STOP
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            // Low stop bit: drop the byte and rearm at once; a new start
            // needs a fresh 1->0 edge anyway.
            state    <= RX_IDLE;
            if (rx_s) begin
              rx_data     <= shreg;
              rx_byte_vld <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_comm.sv
// Host serial endpoint: assembles 3 received bytes into cmd/cmd_rdy, transmits single response bytes.
// Latency: cmd_rdy one clk after the third rx_byte_vld; TX start bit one clk after send_resp, resp_sent 10*BAUD_DIV clk later.
// Backpressure: bytes received while cmd_rdy are dropped until clr_cmd_rdy; send_resp ignored while a frame is in flight.
// Ports: clk, rst_n, RX (host line in), TX (host line out), bus (core side, slave modport).
module uart_cmd_comm import uart_cmd_pkg::*; #(
  parameter int BAUD_DIV = 2604,
  parameter int TO_BITS  = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RX,
  output logic            TX,
  uart_cmd_comm_if.slave  bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);

  logic [7:0] rx_data;
  logic       rx_byte_vld;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (RX),
    .rx_data     (rx_data),
    .rx_byte_vld (rx_byte_vld)
  );

  // ---------------- command assembly + inter-byte timeout ----------------
  logic [1:0]         byte_idx;
  logic [23:0]        cmd_r;
  logic               cmd_rdy_r;
  logic [TO_BITS-1:0] to_cnt;

  assign bus.cmd     = cmd_r;
  assign bus.cmd_rdy = cmd_rdy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx  <= '0;
      cmd_r     <= '0;
      cmd_rdy_r <= 1'b0;
      to_cnt    <= '0;
    end else if (bus.clr_cmd_rdy) begin
      // Clear beats a coincident byte; cmd keeps its last value.
      cmd_rdy_r <= 1'b0;
      byte_idx  <= '0;
      to_cnt    <= '0;
    end else if (rx_byte_vld) begin
      to_cnt <= '0;
      if (!cmd_rdy_r) begin
        case (byte_idx)
          2'd0:    cmd_r[23:16] <= rx_data;
          2'd1:    cmd_r[15:8]  <= rx_data;
          default: cmd_r[7:0]   <= rx_data;
        endcase
        if (byte_idx == 2'(CMD_BYTES - 1)) begin
          byte_idx  <= '0;
          cmd_rdy_r <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end else if (byte_idx != 2'd0 && !cmd_rdy_r) begin
      // A partial command idle for 2^TO_BITS clk is abandoned so a host that
      // lost sync realigns on its next command.
      if (&to_cnt) begin
        byte_idx <= '0;
        to_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // ---------------- TX engine ----------------
  logic                  tx_state;
  logic [FRAME_BITS-1:0] tx_sh;   // bit 0 drives the line directly
  logic [CW-1:0]         tx_cnt;
  logic [3:0]            tx_bit;
  logic                  resp_sent_r;

  assign TX            = tx_sh[0];
  assign bus.resp_sent = resp_sent_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_sh       <= '1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      resp_sent_r <= 1'b0;
    end else begin
      resp_sent_r <= 1'b0;
      if (tx_state == TX_IDLE) begin
        // No restart in the resp_sent clk so the core sees one clean pulse per frame.
        if (bus.send_resp && !resp_sent_r) begin
          tx_sh    <= {1'b1, bus.resp_data, 1'b0};
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_state <= TX_XMIT;
        end
      end else if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[FRAME_BITS-1:1]};  // refill with idle-high
        if (tx_bit == 4'(FRAME_BITS - 1)) begin
          tx_state    <= TX_IDLE;
          resp_sent_r <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_comm.sv
// Scoreboard bench for uart_cmd_comm: random and directed host traffic,
// expected commands/frames queued at issue time, monitors pop and compare.
module tb_uart_cmd_comm;

  localparam int B   = 16;
  localparam int TOB = 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rx_line = 1'b1;
  logic tx;

  uart_cmd_comm_if bus();

  uart_cmd_comm #(.BAUD_DIV(B), .TO_BITS(TOB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx_line),
    .TX    (tx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: bytes of the command being collected, whether a
  // command is pending, and what the monitors should see next.
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  m_part[$];
  bit          m_ready = 1'b0;
  int          n_resp = 0;
  int          n_exp_resp = 0;
  int          tx_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expected event did not occur as required", name);
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (!m_ready) begin
      m_part.push_back(b);
      if (m_part.size() == 3) begin
        exp_cmd_q.push_back({m_part[0], m_part[1], m_part[2]});
        m_part.delete();
        m_ready = 1'b1;
      end
    end
  endfunction

  // One 8N1 frame on RX; good=0 sends a low stop bit.
  task automatic send_byte(input logic [7:0] b, input bit good);
    @(negedge clk) rx_line = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (B) @(negedge clk);
    end
    if (good) model_byte(b);
    rx_line = good;
    repeat (B) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n > (1 << TOB) + 20) m_part.delete();  // partial command timed out
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1); idle($urandom_range(2, 20));
    send_byte(b1, 1'b1); idle($urandom_range(2, 20));
    send_byte(b2, 1'b1); idle($urandom_range(2, 20));
  endtask

  task automatic wait_rdy(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1) return;
    end
    fail_now(name);
  endtask

  task automatic clr();
    @(negedge clk) bus.clr_cmd_rdy = 1'b1;
    @(negedge clk) bus.clr_cmd_rdy = 1'b0;
    m_ready = 1'b0;
    m_part.delete();
    check("clr_cmd_rdy_low", 32'(bus.cmd_rdy), 32'd0);
  endtask

  task automatic tx_send(input logic [7:0] d);
    @(negedge clk) begin bus.resp_data = d; bus.send_resp = 1'b1; end
    exp_tx_q.push_back(d);
    n_exp_resp++;
    @(negedge clk) bus.send_resp = 1'b0;
  endtask

  task automatic tx_poke(input logic [7:0] d);  // issued mid-frame, must be ignored
    @(negedge clk) begin bus.resp_data = d; bus.send_resp = 1'b1; end
    @(negedge clk) bus.send_resp = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int start;
    start = n_resp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_resp != start) return;
    end
    fail_now(name);
  endtask

  // Command monitor: every rising cmd_rdy must match the next queued command,
  // and cmd must still hold that value once cmd_rdy is released.
  initial begin : cmd_mon
    logic        prev_rdy;
    logic [23:0] last_exp;
    prev_rdy = 1'b0;
    last_exp = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.cmd_rdy && !prev_rdy) begin
          if (exp_cmd_q.size() == 0) fail_now("cmd_unexpected");
          else begin
            last_exp = exp_cmd_q.pop_front();
            check("cmd_value", 32'(bus.cmd), 32'(last_exp));
          end
        end
        if (!bus.cmd_rdy && prev_rdy) check("cmd_held_after_clr", 32'(bus.cmd), 32'(last_exp));
      end
      prev_rdy = rst_n ? bus.cmd_rdy : 1'b0;
    end
  end

  // TX monitor: decode each frame at mid-bit and compare with the queue.
  initial begin : tx_mon
    logic       prev;
    logic [9:0] fr;
    logic [7:0] e;
    bit         ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !tx) begin
        tx_start_cyc = cyc;
        ab = 1'b0;
        for (int i = 0; i < 10; i++) begin
          for (int k = 0; k < ((i == 0) ? B / 2 : B); k++) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
          end
          fr[i] = tx;
        end
        if (ab) begin
          if (exp_tx_q.size() > 0) e = exp_tx_q.pop_front();
        end else if (exp_tx_q.size() == 0) begin
          fail_now("tx_unexpected_frame");
        end else begin
          e = exp_tx_q.pop_front();
          check("tx_frame", 32'(fr), 32'({1'b1, e, 1'b0}));
        end
      end
      prev = tx;
    end
  end

  // resp_sent monitor: each pulse lands exactly one frame after the start bit.
  initial begin : resp_mon
    forever begin
      @(negedge clk);
      if (rst_n && bus.resp_sent) begin
        n_resp++;
        check("resp_sent_latency", 32'(cyc - tx_start_cyc), 32'(10 * B));
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp_data   = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_cmd", 32'(bus.cmd), 32'd0);
    check("reset_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("reset_resp_sent", 32'(bus.resp_sent), 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Basic command, then bytes while ready are dropped.
    send_cmd(8'h02, 8'h25, 8'h1A);
    wait_rdy("rdy_02251a");
    for (int i = 0; i < 3; i++) begin send_byte(8'hFF, 1'b1); idle(5); end
    check("cmd_stable_while_rdy", 32'(bus.cmd), 32'h0002251A);
    check("cmd_rdy_still_set", 32'(bus.cmd_rdy), 32'd1);
    clr();
    send_cmd(8'h01, 8'h00, 8'h05);
    wait_rdy("rdy_010005");
    clr();

    // Framing error byte is dropped without advancing the index.
    send_byte(8'h44, 1'b0);
    idle(30);
    send_cmd(8'h11, 8'h22, 8'h33);
    wait_rdy("rdy_112233");
    clr();

    // A short low glitch must not start a byte.
    @(negedge clk) rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    idle(40);
    send_cmd(8'hAB, 8'hCD, 8'hEF);
    wait_rdy("rdy_after_glitch");
    clr();

    // Timeout abandons a partial command.
    send_byte(8'hAA, 1'b1);
    idle(300);
    send_cmd(8'h01, 8'h02, 8'h03);
    wait_rdy("rdy_010203");
    clr();

    // Randomized commands with occasional framing errors, timeouts and extras.
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) begin send_byte(8'($urandom), 1'b0); idle(20); end
      if ($urandom_range(0, 2) == 0) begin send_byte(8'($urandom), 1'b1); idle(300); end
      send_cmd(8'($urandom), 8'($urandom), 8'($urandom));
      wait_rdy("rdy_random");
      if ($urandom_range(0, 1) == 1) begin send_byte(8'($urandom), 1'b1); idle(10); end
      clr();
    end

    // TX: one frame, with a send_resp mid-frame that must be ignored.
    tx_send(8'hA5);
    idle(50);
    tx_poke(8'h3C);
    wait_resp("resp_a5");
    idle(200);
    for (int r = 0; r < 3; r++) begin
      tx_send(8'($urandom));
      wait_resp("resp_random");
      idle($urandom_range(1, 10));
    end
    check("resp_count", 32'(n_resp), 32'(n_exp_resp));

    // Full duplex.
    fork
      begin tx_send(8'h5A); wait_resp("resp_5a_duplex"); end
      begin send_cmd(8'h03, 8'h00, 8'h00); wait_rdy("rdy_030000_duplex"); end
    join
    idle(5);

    // Reset in the middle of a TX frame with cmd_rdy still set.
    tx_send(8'h33);
    idle(50);
    r0 = n_resp;
    rst_n = 1'b0;
    m_part.delete();
    m_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_line", 32'(tx), 32'd1);
    check("rst_mid_tx_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("rst_mid_tx_cmd", 32'(bus.cmd), 32'd0);
    idle(5);
    rst_n = 1'b1;
    idle(300);
    check("no_resp_after_reset", 32'(n_resp), 32'(r0));

    // Recovery after reset.
    send_cmd(8'h7E, 8'h81, 8'h42);
    wait_rdy("rdy_after_reset");
    clr();
    idle(20);

    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_comm.md
Name: uart_cmd_comm

Overview:
- Host-side serial endpoint for the scope digital core.
- Deserializes UART bytes from the host and assembles them into the 24-bit command presented as cmd/cmd_rdy, which the core consumes and clears with clr_cmd_rdy.
- Serializes single response bytes (resp_data/send_resp) back to the host and reports completion on resp_sent.
- Sits between the board RX/TX pins and the command/config logic of dig_core.

Parameters:
BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); must be >= 8
TO_BITS, 20, inter-byte timeout of 2^TO_BITS clk cycles for discarding a partial command

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
RX  in  1  serial input from host, idle high, asynchronous to clk
TX  out  1  serial output to host, idle high
cmd  out  24  assembled command; byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0]
cmd_rdy  out  1  level; cmd is valid
clr_cmd_rdy  in  1  one-clk pulse from the core; releases cmd and re-arms assembly
resp_data  in  8  response byte to transmit
send_resp  in  1  one-clk pulse; start transmitting resp_data
resp_sent  out  1  one-clk pulse; response frame fully sent

Behaviour:
- Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0. Byte index = 0, RX and TX engines idle. The 2-flop RX synchronizer presets to 1.
- Frame format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1).
- RX engine states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized RX 1->0 edge.
  - START: wait BAUD_DIV/2 cycles and re-sample. RX=1 is a glitch and returns to IDLE; RX=0 goes to DATA.
  - DATA: sample every BAUD_DIV cycles, 8 samples.
  - STOP: sample once after BAUD_DIV cycles. Stop=1 gives rx_byte_vld for one clk. Stop=0 is a framing error: the byte is dropped, the byte index is unchanged, and the engine returns to IDLE without waiting for line high.
- Assembly, on rx_byte_vld:
  - Byte index 0 -> cmd[23:16]; index 1 -> cmd[15:8]; index 2 -> cmd[7:0].
  - On the byte at index 2, cmd_rdy=1 in the clk after rx_byte_vld and the index returns to 0.
  - cmd fields update only while cmd_rdy=0. While cmd_rdy=1, received bytes are discarded and cmd is held stable.
- clr_cmd_rdy: next clk sets cmd_rdy=0 and byte index=0; cmd retains its value. If clr_cmd_rdy and rx_byte_vld coincide, clr wins and the byte is discarded.
- Timeout:
  - Counter resets on every rx_byte_vld and runs only while 0 < byte index < 3 and cmd_rdy=0.
  - At 2^TO_BITS cycles the byte index returns to 0; the partial cmd bytes are ignored and later overwritten.
- TX engine states: IDLE, XMIT.
  - send_resp in IDLE latches resp_data into a 10-bit shift register {1, data, 0}. TX drives the start bit from the next clk.
  - Each bit is held exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles.
  - After the stop bit period, resp_sent=1 for one clk and the engine returns to IDLE, TX=1.
  - send_resp during XMIT is ignored; resp_data is not sampled.
  - send_resp in the same clk resp_sent pulses is ignored. The next accepted send_resp is one clk later at the earliest.
- RX and TX are fully independent; full-duplex traffic is legal.
- Asynchronous reset mid-frame aborts both engines immediately: TX=1, and a partial cmd is lost. After reset release, a host frame already in progress may be mis-framed; the timeout resync recovers.

Decomposition:
- Package uart_cmd_pkg:
  - RX state enum.
  - TX state enum.
  - constants CMD_BYTES=3 and FRAME_BITS=10.
- One sub-module: uart_rx, covering synchronizer, RX FSM, baud counter, bit counter and shift register. Outputs rx_data[7:0] and rx_byte_vld.
- Assembly, timeout and the TX engine live in the top module.

Test Plan:
- BAUD_DIV=16, host sends 0x02, 0x25, 0x1A -> one clk after the third stop-bit sample, cmd_rdy=1 and cmd=0x02251A. clr_cmd_rdy pulse -> cmd_rdy=0 next clk, cmd still 0x02251A.
- With cmd_rdy=1, host sends 0xFF x3 -> cmd stays 0x02251A. After clr, next 0x01, 0x00, 0x05 -> cmd=0x010005.
- Framing error: byte 0x44 sent with stop=0, then 0x11, 0x22, 0x33 valid -> cmd=0x112233 (errored byte dropped). A 3-cycle RX low glitch -> no byte.
- Timeout: TO_BITS=8, send 0xAA, idle 300 clk, send 0x01, 0x02, 0x03 -> cmd=0x010203, cmd_rdy=1.
- TX: send_resp with resp_data=0xA5 -> TX low from the next clk for 16 clk, then bits 1,0,1,0,0,1,0,1, stop high. resp_sent pulses once, 160 clk after the start bit begins. A second send_resp mid-frame -> no extra frame.
- Full duplex plus reset: a TX frame of 0x5A overlaps an RX command of 0x030000 -> both correct. Assert rst_n mid-TX -> TX=1, cmd_rdy=0, resp_sent never pulses.
